// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings, default latencies and helpers for the multiply/divide sequencer.
package mdu_sequencer_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  // Counter must hold the longer latency, never narrower than 4 bits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// Combinational 64-bit HI/LO result for mult/multu/div/divu, including the divide-by-zero rule.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  output md_result_t        o_res
);

  logic                     w_rt_zero;
  logic [DATA_W-1:0]        w_rt_nz;
  logic signed [63:0]       w_prod_s;
  logic [63:0]              w_prod_u;
  logic signed [DATA_W-1:0] w_quo_s;
  logic signed [DATA_W-1:0] w_rem_s;
  logic [DATA_W-1:0]        w_quo_u;
  logic [DATA_W-1:0]        w_rem_u;

  // Dividers see a non-zero divisor so the unused path never produces X.
  assign w_rt_zero = (i_rt == '0);
  assign w_rt_nz   = w_rt_zero ? DATA_W'(1) : i_rt;

  assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};
  assign w_quo_s  = $signed(i_rs) / $signed(w_rt_nz);
  assign w_rem_s  = $signed(i_rs) % $signed(w_rt_nz);
  assign w_quo_u  = i_rs / w_rt_nz;
  assign w_rem_u  = i_rs % w_rt_nz;

  always_comb begin
    o_res.hi = w_prod_s[63:32];
    o_res.lo = w_prod_s[31:0];
    case (i_op)
      MD_MULTU: begin
        o_res.hi = w_prod_u[63:32];
        o_res.lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        o_res.hi = w_rt_zero ? i_rs : DATA_W'(w_rem_s);
        o_res.lo = w_rt_zero ? 32'hFFFF_FFFF : DATA_W'(w_quo_s);
      end
      MD_DIVU: begin
        o_res.hi = w_rt_zero ? i_rs : w_rem_u;
        o_res.lo = w_rt_zero ? 32'hFFFF_FFFF : w_quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: busy countdown, HI/LO commit, mfhi/mflo read, D-stage stall.
// Optional MDU_DIV0_GUARD_EN: divides by zero are dropped instead of running the full latency.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mudi_op,
  input  logic              hi_write,
  input  logic              lo_write,
  input  logic              hi_read,
  input  logic              lo_read,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              req,
  input  logic              md_use_d,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  md_result_t        r_pend;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_busy;

  md_result_t        w_res;
  logic              w_is_div;
  logic              w_issue;

  mdu_arith u_arith (
    .i_op  (mudi_op),
    .i_rs  (rs_val),
    .i_rt  (rt_val),
    .o_res (w_res)
  );

  assign w_is_div = (mudi_op == MD_DIV) || (mudi_op == MD_DIVU);

`ifdef MDU_DIV0_GUARD_EN
  logic w_div0;
  assign w_div0  = w_is_div && (rt_val == '0);
  assign w_issue = start && !req && !w_div0;
`else
  assign w_issue = start && !req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_pend  <= w_res;
            r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
          if (hi_write && !req) r_hi <= rs_val;
          if (lo_write && !req) r_lo <= rs_val;
        end
        ST_RUN: begin
          // Starts and moves arriving here are blocked by stall upstream and ignored.
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_pend.hi;
            r_lo    <= r_pend.lo;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = md_use_d && (start || r_busy);
  assign rdata = hi_read ? r_hi : (lo_read ? r_lo : '0);

endmodule
